// File: rtl/amp_i2c_pkg.sv
`default_nettype none
// ============================================================================
// amp_i2c_pkg : shared constants for the amp config-bus I2C target
// Rev 1.0
// ============================================================================
package amp_i2c_pkg;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_DEV_ADDR = 3'd1;
    localparam logic [2:0] S_REG_ADDR = 3'd2;
    localparam logic [2:0] S_WR_DATA  = 3'd3;
    localparam logic [2:0] S_RD_DATA  = 3'd4;
    localparam logic [2:0] S_RD_ACK   = 3'd5;
    localparam logic [2:0] S_IGNORE   = 3'd6;

    localparam logic C_ACK  = 1'b0;
    localparam logic C_NACK = 1'b1;

    // Device address shared with the amp I2C master
    localparam logic [6:0] C_DEF_I2C_ADDR = 7'h20;

endpackage : amp_i2c_pkg
`default_nettype wire

// File: rtl/i2c_line_sync.sv
`default_nettype none
// ============================================================================
// i2c_line_sync : 2-flop synchronizer + history flop, edge/START/STOP detect
// Rev 1.0
// ============================================================================
module i2c_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop,
    output logic o_sda
);

    logic [1:0] r_scl_sync;
    logic [1:0] r_sda_sync;
    logic       r_scl_hist;
    logic       r_sda_hist;
    logic       w_scl;
    logic       w_sda;

    // Reset to the idle-bus level so no edge is seen on release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_sync <= 2'b11;
            r_sda_sync <= 2'b11;
            r_scl_hist <= 1'b1;
            r_sda_hist <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[0], i_scl};
            r_sda_sync <= {r_sda_sync[0], i_sda};
            r_scl_hist <= r_scl_sync[1];
            r_sda_hist <= r_sda_sync[1];
        end
    end

    assign w_scl      = r_scl_sync[1];
    assign w_sda      = r_sda_sync[1];
    assign o_sda      = w_sda;
    assign o_scl_rise = w_scl & ~r_scl_hist;
    assign o_scl_fall = ~w_scl & r_scl_hist;
    assign o_start    = w_scl & r_scl_hist & ~w_sda & r_sda_hist;
    assign o_stop     = w_scl & r_scl_hist & w_sda & ~r_sda_hist;

endmodule : i2c_line_sync
`default_nettype wire

// File: rtl/amp_i2c_slave.sv
`default_nettype none
// ============================================================================
// amp_i2c_slave : I2C target with auto-incrementing pointer into a byte file
// Rev 1.0
// ============================================================================
module amp_i2c_slave
    import amp_i2c_pkg::*;
#(
    parameter logic [6:0] I2C_ADDR = C_DEF_I2C_ADDR,
    parameter int         REGS     = 64
) (
    input  logic              clk_in,
    input  logic              resetb,
    input  logic              scl,
    input  logic              sdai,
    output logic              sdao,
    output logic [8*REGS-1:0] reg_q,
    output logic              wr_stb,
    output logic [7:0]        wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy
);

    localparam int         AW         = (REGS > 1) ? $clog2(REGS) : 1;
    localparam logic [8:0] c_regs_lim = 9'(REGS);

    logic          w_rise, w_fall, w_start, w_stop, w_sda;
    logic [2:0]    r_state, w_state_nx;
    logic [3:0]    r_cnt;
    logic [6:0]    r_shift;
    logic [7:0]    r_tx, r_ptr, r_wr_addr, r_wr_data;
    logic          r_sdao, r_stb;
    logic [7:0]    r_mem [REGS];
    logic [7:0]    w_byte, w_rd_byte;
    logic [AW-1:0] w_idx;
    logic          w_in_range;

    i2c_line_sync u_sync (
        .clk        (clk_in),
        .rst_n      (resetb),
        .i_scl      (scl),
        .i_sda      (sdai),
        .o_scl_rise (w_rise),
        .o_scl_fall (w_fall),
        .o_start    (w_start),
        .o_stop     (w_stop),
        .o_sda      (w_sda)
    );

    assign w_byte     = {r_shift, w_sda};
    assign w_idx      = r_ptr[AW-1:0];
    assign w_in_range = ({1'b0, r_ptr} < c_regs_lim);
    assign w_rd_byte  = w_in_range ? r_mem[w_idx] : 8'hFF;

    always_ff @(posedge clk_in or negedge resetb) begin
        if (!resetb) r_state <= S_IDLE;
        else         r_state <= w_state_nx;
    end

    // Transitions out of a byte happen on the 9th rise; the following fall
    // (r_cnt==9) then finishes the ACK slot in the new state.
    always_comb begin
        w_state_nx = r_state;
        if (w_start) begin
            w_state_nx = S_DEV_ADDR;
        end else if (w_stop) begin
            w_state_nx = S_IDLE;
        end else if (w_rise) begin
            case (r_state)
                S_DEV_ADDR: begin
                    if (r_cnt == 4'd7 && w_byte[7:1] != I2C_ADDR)
                        w_state_nx = S_IGNORE;
                    else if (r_cnt == 4'd8)
                        w_state_nx = r_shift[0] ? S_RD_DATA : S_REG_ADDR;
                end
                S_REG_ADDR: if (r_cnt == 4'd8) w_state_nx = S_WR_DATA;
                S_RD_ACK:   w_state_nx = w_sda ? S_IGNORE : S_RD_DATA;
                default:    w_state_nx = r_state;
            endcase
        end else if (w_fall && r_state == S_RD_DATA && r_cnt == 4'd8) begin
            w_state_nx = S_RD_ACK;
        end
    end

    always_comb begin
        busy    = (r_state != S_IDLE) && (r_state != S_IGNORE);
        sdao    = r_sdao;
        wr_stb  = r_stb;
        wr_addr = r_wr_addr;
        wr_data = r_wr_data;
    end

    always_ff @(posedge clk_in or negedge resetb) begin
        if (!resetb) begin
            r_cnt     <= '0;
            r_shift   <= '0;
            r_tx      <= '0;
            r_ptr     <= '0;
            r_sdao    <= C_NACK;
            r_stb     <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            for (int i = 0; i < REGS; i++) r_mem[i] <= '0;
        end else begin
            r_stb <= 1'b0;
            if (w_start) begin
                r_cnt  <= '0;
                r_sdao <= C_NACK;
            end else if (w_stop) begin
                r_sdao <= C_NACK;
            end else if (w_rise) begin
                if (r_cnt != 4'd9) r_cnt <= r_cnt + 4'd1;
                if (r_cnt < 4'd8)  r_shift <= w_byte[6:0];
                if (r_state == S_REG_ADDR && r_cnt == 4'd7) r_ptr <= w_byte;
                if (r_state == S_WR_DATA && r_cnt == 4'd7) begin
                    if (w_in_range) begin
                        r_mem[w_idx] <= w_byte;
                        r_stb        <= 1'b1;
                        r_wr_addr    <= r_ptr;
                        r_wr_data    <= w_byte;
                    end
                    r_ptr <= r_ptr + 8'd1;
                end
                if (r_state == S_RD_ACK && !w_sda) r_ptr <= r_ptr + 8'd1;
            end else if (w_fall) begin
                case (r_state)
                    S_DEV_ADDR, S_REG_ADDR, S_WR_DATA: begin
                        if (r_cnt == 4'd8) begin
                            r_sdao <= C_ACK;
                        end else if (r_cnt == 4'd9) begin
                            r_sdao <= C_NACK;
                            r_cnt  <= '0;
                        end
                    end
                    S_RD_DATA: begin
                        if (r_cnt == 4'd9) begin
                            r_sdao <= w_rd_byte[7];
                            r_tx   <= {w_rd_byte[6:0], 1'b0};
                            r_cnt  <= '0;
                        end else if (r_cnt == 4'd8) begin
                            r_sdao <= C_NACK;
                        end else if (r_cnt != 4'd0) begin
                            r_sdao <= r_tx[7];
                            r_tx   <= {r_tx[6:0], 1'b0};
                        end
                    end
                    default: r_sdao <= C_NACK;
                endcase
            end
        end
    end

    for (genvar g = 0; g < REGS; g++) begin : g_regq
        assign reg_q[8*g +: 8] = r_mem[g];
    end

endmodule : amp_i2c_slave
`default_nettype wire

// File: tb/tb_amp_i2c_slave.sv
`default_nettype none
// ============================================================================
// tb_amp_i2c_slave : transaction-level model + per-cycle strobe/image compare
// Rev 1.0
// ============================================================================
module tb_amp_i2c_slave;

    localparam int         REGS = 64;
    localparam logic [6:0] ADDR = 7'h20;

    logic              clk_in = 1'b0;
    logic              resetb = 1'b0;
    logic              scl    = 1'b1;
    logic              m_sda  = 1'b1;
    logic              sdai;
    logic              sdao, wr_stb, busy;
    logic [7:0]        wr_addr, wr_data;
    logic [8*REGS-1:0] reg_q;

    assign sdai = m_sda & sdao;   // open-drain wired-AND
    always #5 clk_in = ~clk_in;

    amp_i2c_slave #(.I2C_ADDR(ADDR), .REGS(REGS)) dut (
        .clk_in  (clk_in),
        .resetb  (resetb),
        .scl     (scl),
        .sdai    (sdai),
        .sdao    (sdao),
        .reg_q   (reg_q),
        .wr_stb  (wr_stb),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy)
    );

    int         total = 0;
    int         bad   = 0;
    logic [7:0] m_regs [REGS];   // transaction-level contents (read predictions)
    logic [7:0] m_img  [REGS];   // contents as of the last observed strobe
    logic [15:0] exp_q [$];      // expected {addr, data} strobes in order

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [8*REGS-1:0] img_vec();
        logic [8*REGS-1:0] v;
        for (int i = 0; i < REGS; i++) v[8*i +: 8] = m_img[i];
        return v;
    endfunction

    function automatic int nonzero_bytes();
        int c = 0;
        for (int i = 0; i < REGS; i++) if (reg_q[8*i +: 8] != 8'h00) c++;
        return c;
    endfunction

    // ---------------- cycle compare process ----------------
    logic [8*REGS-1:0] last_q, last_img, cur_img;
    logic [15:0]       e;
    logic              prev_stb = 1'b0;
    int                diff_idx;

    always @(negedge clk_in) begin
        if (resetb) begin
            if (wr_stb) begin
                chk("stb_single_cycle", prev_stb, 0);
                if (exp_q.size() == 0) begin
                    chk("stb_unexpected", wr_stb, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", wr_addr, e[15:8]);
                    chk("wr_data", wr_data, e[7:0]);
                    m_img[int'(e[15:8])] = e[7:0];
                end
            end
            cur_img = img_vec();
            if (cur_img !== last_img || reg_q !== last_q) begin
                total++;
                if (reg_q !== cur_img) begin
                    bad++;
                    diff_idx = 0;
                    for (int i = REGS - 1; i >= 0; i--)
                        if (reg_q[8*i +: 8] !== cur_img[8*i +: 8]) diff_idx = i;
                    $display("FAIL reg_q byte %0d: got %0h expected %0h", diff_idx,
                             reg_q[8*diff_idx +: 8], cur_img[8*diff_idx +: 8]);
                end
            end
            last_img = cur_img;
            last_q   = reg_q;
        end
        prev_stb = wr_stb;
    end

    // ---------------- bus master tasks ----------------
    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic bus_start();
        m_sda = 1'b1; wait_clk(6);
        scl   = 1'b1; wait_clk(6);
        m_sda = 1'b0; wait_clk(6);
        scl   = 1'b0;
    endtask

    task automatic bus_stop();
        wait_clk(4); m_sda = 1'b0;
        wait_clk(4); scl   = 1'b1;
        wait_clk(6); m_sda = 1'b1;
        wait_clk(10);
    endtask

    task automatic bit_xfer(input logic b, output logic rb);
        wait_clk(4); m_sda = b;
        wait_clk(4); scl   = 1'b1;
        wait_clk(4); rb    = sdai;
        wait_clk(4); scl   = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic d;
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], d);
        bit_xfer(1'b1, ack);
    endtask

    task automatic recv_byte(input logic mack, output logic [7:0] d);
        logic x;
        for (int i = 7; i >= 0; i--) bit_xfer(1'b1, d[i]);
        bit_xfer(mack, x);
    endtask

    // ---------------- transaction-level model ----------------
    task automatic wr_txn(input logic [7:0] dev, input logic [7:0] ptr,
                          input logic [31:0] dat, input int n);
        logic       ack, hit;
        logic [7:0] p, b;
        hit = (dev[7:1] == ADDR) && !dev[0];
        bus_start();
        chk("busy_after_start", busy, 1);
        send_byte(dev, ack);
        chk("dev_ack", ack, hit ? 0 : 1);
        if (!hit) chk("busy_after_addr_nack", busy, 0);
        send_byte(ptr, ack);
        chk("ptr_ack", ack, hit ? 0 : 1);
        p = ptr;
        for (int k = 0; k < n; k++) begin
            b = dat[31-8*k -: 8];
            if (hit && int'(p) < REGS) begin
                exp_q.push_back({p, b});
                m_regs[int'(p)] = b;
            end
            if (hit) p = p + 8'd1;
            send_byte(b, ack);
            chk("data_ack", ack, hit ? 0 : 1);
        end
        bus_stop();
        chk("busy_after_stop", busy, 0);
        chk("stb_pending", exp_q.size(), 0);
    endtask

    task automatic rd_txn(input logic [7:0] ptr, input int n,
                          output logic [7:0] d0, output logic [7:0] d1);
        logic       ack, last;
        logic [7:0] p, d, expd;
        d0 = 8'h00; d1 = 8'h00;
        bus_start();
        send_byte({ADDR, 1'b0}, ack); chk("rd_dev_w_ack", ack, 0);
        send_byte(ptr, ack);          chk("rd_ptr_ack", ack, 0);
        p = ptr;
        bus_start();
        send_byte({ADDR, 1'b1}, ack); chk("rd_dev_r_ack", ack, 0);
        for (int k = 0; k < n; k++) begin
            last = (k == n - 1);
            recv_byte(last, d);
            expd = (int'(p) < REGS) ? m_regs[int'(p)] : 8'hFF;
            chk("rd_data", d, expd);
            if (k == 0) d0 = d; else d1 = d;
            if (!last) p = p + 8'd1;
        end
        wait_clk(4);
        chk("sdao_released_after_nack", sdao, 1);
        chk("busy_after_master_nack", busy, 0);
        bus_stop();
        chk("busy_after_rd_stop", busy, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [7:0] r0, r1;
        logic       ack, x;
        for (int i = 0; i < REGS; i++) begin m_regs[i] = 8'h00; m_img[i] = 8'h00; end

        wait_clk(3);
        chk("rst_sdao", sdao, 1);
        chk("rst_busy", busy, 0);
        chk("rst_wr_stb", wr_stb, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_regq_nonzero", nonzero_bytes(), 0);
        resetb = 1'b1;
        wait_clk(5);

        // 0x40 is one past the last implemented register: ACKed, not stored
        wr_txn(8'h40, 8'h40, 32'h1800_0000, 1);
        wr_txn(8'h40, 8'h3F, 32'h1800_0000, 1);
        chk("lit_reg3f", reg_q[8*63 +: 8], 8'h18);

        // wrong device address
        wr_txn(8'h42, 8'h10, 32'h9900_0000, 1);

        // block write with auto-increment
        wr_txn(8'h40, 8'h10, 32'hAABB_CC00, 3);
        chk("lit_reg10_12", reg_q[8*16 +: 24], 24'hCCBBAA);

        // pre-load and read back with repeated START
        wr_txn(8'h40, 8'h35, 32'h085A_0000, 2);
        rd_txn(8'h35, 2, r0, r1);
        chk("lit_rd0", r0, 8'h08);
        chk("lit_rd1", r1, 8'h5A);

        // out-of-range pointer
        wr_txn(8'h40, 8'h45, 32'h7700_0000, 1);
        rd_txn(8'h45, 1, r0, r1);
        chk("lit_rd_oor", r0, 8'hFF);

        // pointer wrap 0xFF -> 0x00
        wr_txn(8'h40, 8'hFF, 32'h1122_0000, 2);
        chk("lit_wrap_reg0", reg_q[7:0], 8'h22);

        // reset during bit 4 of a data byte
        bus_start();
        send_byte(8'h40, ack); chk("mid_dev_ack", ack, 0);
        send_byte(8'h05, ack); chk("mid_ptr_ack", ack, 0);
        for (int i = 0; i < 3; i++) bit_xfer(1'b0, x);
        wait_clk(4); m_sda = 1'b1;
        wait_clk(2);
        #1 resetb = 1'b0;
        #1;
        chk("mid_rst_sdao", sdao, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_wr_stb", wr_stb, 0);
        chk("mid_rst_regq_nonzero", nonzero_bytes(), 0);
        for (int i = 0; i < REGS; i++) begin m_regs[i] = 8'h00; m_img[i] = 8'h00; end
        exp_q.delete();
        wait_clk(3);
        scl = 1'b1; m_sda = 1'b1;
        wait_clk(3);
        resetb = 1'b1;
        wait_clk(5);
        wr_txn(8'h40, 8'h40, 32'h1800_0000, 1);
        wr_txn(8'h40, 8'h05, 32'h1800_0000, 1);
        chk("lit_post_rst_reg5", reg_q[8*5 +: 8], 8'h18);
        chk("lit_post_rst_reg0", reg_q[7:0], 8'h00);

        wait_clk(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_amp_i2c_slave
`default_nettype wire
